// File: rtl/mem_dbus_ctrl_pkg.sv
// rtl/mem_dbus_ctrl_pkg.sv - shared FSM state encoding and access size codes
package mem_dbus_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/mem_dbus_ctrl.sv
// rtl/mem_dbus_ctrl.sv - MEM-stage data-bus controller: one outstanding access, flush-safe
module mem_dbus_ctrl
  import mem_dbus_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                m_en,
  input  logic [DATA_W/8-1:0] m_wen,
  input  logic [ADDR_W-1:0]   m_paddr,
  input  logic [DATA_W-1:0]   m_wdata,
  input  logic [1:0]          m_size,
  input  logic                flush,
  output logic                mem_stall,
  output logic [DATA_W-1:0]   m_rdata,
  output logic                m_rvalid,
  output logic                bus_req,
  output logic                bus_wr,
  output logic [1:0]          bus_size,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W/8-1:0] bus_wstrb,
  output logic [DATA_W-1:0]   bus_wdata,
  input  logic                bus_addr_ok,
  input  logic                bus_data_ok,
  input  logic [DATA_W-1:0]   bus_rdata
);

  state_t r_state;
  logic   r_abort;
  logic   w_capture;
  logic   w_abort_nxt;

  assign w_capture   = (r_state == ST_IDLE) && m_en && !flush;
  assign w_abort_nxt = r_abort || (flush && ((r_state == ST_REQ) || (r_state == ST_WAIT)));

  // Bus outputs double as the capture registers, so they stay stable until addr_ok.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_abort   <= 1'b0;
      bus_req   <= 1'b0;
      bus_wr    <= 1'b0;
      bus_size  <= SIZE_WORD;
      bus_addr  <= '0;
      bus_wstrb <= '0;
      bus_wdata <= '0;
      m_rdata   <= '0;
      m_rvalid  <= 1'b0;
    end else begin
      m_rvalid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_capture) begin
            r_state   <= ST_REQ;
            bus_req   <= 1'b1;
            bus_wr    <= |m_wen;
            bus_size  <= m_size;
            bus_addr  <= m_paddr;
            bus_wstrb <= m_wen;
            bus_wdata <= m_wdata;
          end
        end
        ST_REQ: begin
          r_abort <= w_abort_nxt;
          if (bus_addr_ok) begin
            bus_req <= 1'b0;
            if (bus_data_ok) begin
              r_state  <= ST_DONE;
              m_rdata  <= bus_rdata;
              m_rvalid <= !bus_wr && !w_abort_nxt;
            end else begin
              r_state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          r_abort <= w_abort_nxt;
          if (bus_data_ok) begin
            r_state  <= ST_DONE;
            m_rdata  <= bus_rdata;
            m_rvalid <= !bus_wr && !w_abort_nxt;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_abort <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Once aborted, the pipeline only waits if a new access is already queued behind us.
  always_comb begin
    mem_stall = 1'b0;
    if (rst) begin
      if (r_abort) begin
        mem_stall = m_en;
      end else begin
        case (r_state)
          ST_IDLE: mem_stall = m_en && !flush;
          ST_REQ:  mem_stall = 1'b1;
          ST_WAIT: mem_stall = 1'b1;
          default: mem_stall = 1'b0;
        endcase
      end
    end
  end

endmodule
